// File: rtl/hmulti_sink_pkg.sv
// Shared types and the round-robin pick helper for hmulti_sink.
`include "hglobal.sv"
package hmulti_sink_pkg;

  localparam int MAX_NCH = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of elig at or after ptr, wrapping within n channels.
  function automatic rr_pick_t rr_pick(input logic [MAX_NCH-1:0] elig,
                                       input logic [3:0] ptr,
                                       input int unsigned n);
    rr_pick_t    r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 0; k < MAX_NCH; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !r.found && elig[idx[3:0]]) begin
        r.found = 1'b1;
        r.idx   = idx[3:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hglobal.sv
// Shared definitions for the handshake sink family: on/off levels, default payload width and req settle time.
`ifndef HGLOBAL_SV
`define HGLOBAL_SV
`define NS_OFF 1'b0
`define NS_ON 1'b1
`define NS_DATA_SIZE 8
`define NS_REQ_CKS 2
`endif

// File: rtl/hreq_debouncer.sv
// Req debouncer: ckd_req follows req once it has held a new level for CKS samples.
// rdy rises CKS cycles after reset release; no backpressure.
`include "hglobal.sv"
module hreq_debouncer #(
  parameter int CKS = `NS_REQ_CKS
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic ckd_req,
  output logic rdy
);

  localparam int CW = (CKS > 1) ? $clog2(CKS + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(CKS - 1);

  logic [CW-1:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
  logic          ckd_q, ckd_d, rdy_q, rdy_d;

  always_comb begin
    cnt_d  = '0;
    ckd_d  = ckd_q;
    rcnt_d = rcnt_q;
    rdy_d  = rdy_q;
    // any sample matching the current level restarts the stability count
    if (req != ckd_q) begin
      if (cnt_q == LAST) ckd_d = req;
      else               cnt_d = cnt_q + CW'(1);
    end
    if (!rdy_q) begin
      if (rcnt_q == LAST) rdy_d  = 1'b1;
      else                rcnt_d = rcnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      rcnt_q <= '0;
      ckd_q  <= `NS_OFF;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rcnt_q <= rcnt_d;
      ckd_q  <= ckd_d;
      rdy_q  <= rdy_d;
    end
  end

  assign ckd_req = ckd_q;
  assign rdy     = rdy_q;

endmodule

// File: rtl/hmulti_sink.sv
// Multi-channel four-phase sink: debounced reqs, round-robin accept (one per cycle), ack one edge after accept,
// optional per-channel sequence check with sticky error; senders are throttled purely by withholding ack.
`include "hglobal.sv"
module hmulti_sink
  import hmulti_sink_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int DSZ         = `NS_DATA_SIZE,
  parameter int CSZ         = 16,
  parameter int RCV_REQ_CKS = `NS_REQ_CKS,
  parameter int CHK_SEQ     = 1
) (
  input  logic                                  gch_clk,
  input  logic                                  gch_reset,
  output logic                                  gch_ready,
  input  logic [NCH-1:0]                        rcv_req,
  output logic [NCH-1:0]                        rcv_ack,
  input  logic [NCH*DSZ-1:0]                    rcv_data,
  output logic [CSZ-1:0]                        msg_cnt,
  output logic                                  err,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] err_chnl
);

  localparam int   ECW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic ST_INIT = `NS_OFF;
  localparam logic ST_RUN  = `NS_ON;

  logic                 state_q, state_d;
  logic [NCH-1:0]       ckd_req, dbc_rdy, elig;
  logic [NCH-1:0]       ack_q, ack_d, armed_q, armed_d;
  logic [MAX_NCH-1:0]   elig16;
  logic [3:0]           ptr_q, ptr_d;
  logic [CSZ-1:0]       cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [ECW-1:0]       ech_q, ech_d, gidx;
  rr_pick_t             pick;
  logic                 accept, mism;

  for (genvar g = 0; g < NCH; g++) begin : g_dbc
    hreq_debouncer #(.CKS(RCV_REQ_CKS)) u_dbc (
      .clk    (gch_clk),
      .reset  (gch_reset),
      .req    (rcv_req[g]),
      .ckd_req(ckd_req[g]),
      .rdy    (dbc_rdy[g])
    );
  end

  always_ff @(posedge gch_clk) begin
    if (gch_reset) state_q <= ST_INIT;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb gch_ready = (state_q == ST_RUN) && (&dbc_rdy);

  // armed blocks a req that was already high across reset until the sender returns it low
  always_comb begin
    elig   = ckd_req & ~ack_q & armed_q;
    elig16 = '0;
    elig16[NCH-1:0] = elig;
    pick   = rr_pick(elig16, ptr_q, NCH);
    accept = gch_ready && pick.found;
    gidx   = ECW'(pick.idx);
  end

  always_comb begin
    ack_d   = '0;
    armed_d = armed_q | ({NCH{gch_ready}} & ~ckd_req);
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ech_d   = ech_q;
    for (int i = 0; i < NCH; i++) begin
      if (ack_q[i]) ack_d[i] = ckd_req[i];
      else          ack_d[i] = accept && (int'(pick.idx) == i);
    end
    if (state_q == ST_INIT) ack_d = '0;
    if (accept) begin
      ptr_d = (pick.idx == 4'(NCH - 1)) ? 4'd0 : pick.idx + 4'd1;
      if (cnt_q != {CSZ{1'b1}}) cnt_d = cnt_q + CSZ'(1);
    end
    if (mism && !err_q) begin
      err_d = 1'b1;
      ech_d = gidx;
    end
  end

  if (CHK_SEQ != 0) begin : g_seq
    logic [DSZ-1:0] exp_q [NCH];
    logic [DSZ-1:0] smp_dat;

    assign smp_dat = rcv_data[gidx*DSZ +: DSZ];
    assign mism    = accept && (smp_dat != exp_q[gidx]);

    // the expected value advances on every accept, mismatching or not
    always_ff @(posedge gch_clk) begin
      if (gch_reset) begin
        for (int i = 0; i < NCH; i++) exp_q[i] <= '0;
      end else if (accept) begin
        exp_q[gidx] <= exp_q[gidx] + DSZ'(1);
      end
    end
  end else begin : g_noseq
    assign mism = 1'b0;
  end

  always_ff @(posedge gch_clk) begin
    if (gch_reset) begin
      ack_q   <= '0;
      armed_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ech_q   <= '0;
    end else begin
      ack_q   <= ack_d;
      armed_q <= armed_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ech_q   <= ech_d;
    end
  end

  assign rcv_ack  = ack_q;
  assign msg_cnt  = cnt_q;
  assign err      = err_q;
  assign err_chnl = ech_q;

endmodule

// File: tb/tb_hmulti_sink.sv
// Bench for hmulti_sink: a 4-channel instance and a 1-channel instance with a 3-bit counter.
module tb_hmulti_sink;

  localparam int NA = 4;
  localparam int DW = 8;
  localparam int KS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst_a, rdy_a, err_a;
  logic [NA-1:0] req_a, ack_a;
  logic [NA*DW-1:0] dat_a;
  logic [15:0]   cnt_a;
  logic [1:0]    ech_a;

  logic          rst_b, rdy_b, err_b;
  logic [0:0]    req_b, ack_b, ech_b;
  logic [DW-1:0] dat_b;
  logic [2:0]    cnt_b;

  hmulti_sink #(.NCH(NA), .DSZ(DW), .CSZ(16), .RCV_REQ_CKS(KS), .CHK_SEQ(1)) dut_a (
    .gch_clk(clk), .gch_reset(rst_a), .gch_ready(rdy_a), .rcv_req(req_a), .rcv_ack(ack_a),
    .rcv_data(dat_a), .msg_cnt(cnt_a), .err(err_a), .err_chnl(ech_a));

  hmulti_sink #(.NCH(1), .DSZ(DW), .CSZ(3), .RCV_REQ_CKS(KS), .CHK_SEQ(1)) dut_b (
    .gch_clk(clk), .gch_reset(rst_b), .gch_ready(rdy_b), .rcv_req(req_b), .rcv_ack(ack_b),
    .rcv_data(dat_b), .msg_cnt(cnt_b), .err(err_b), .err_chnl(ech_b));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Scoreboard: senders push the payload they offer; monitors pop on each ack rise.
  logic [DW-1:0] qa [NA][$];
  logic [DW-1:0] qb [$];
  typedef struct { int cyc; int ch; } ev_t;
  ev_t log_a [$];

  // Reference model: per-channel expected sequence value, saturating count, first-error latch.
  int      m_cnt, m_ech, m_cntb, n_rise_b;
  bit      m_err, m_errb;
  logic [DW-1:0] m_exp [NA];
  logic [DW-1:0] m_expb;

  initial begin : mon_a
    logic [NA-1:0] prev, rises;
    logic [DW-1:0] d;
    prev = '0; m_cnt = 0; m_err = 0; m_ech = 0;
    foreach (m_exp[i]) m_exp[i] = '0;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        m_cnt = 0; m_err = 0; m_ech = 0; prev = '0;
        foreach (m_exp[i]) m_exp[i] = '0;
        foreach (qa[i]) qa[i].delete();
        continue;
      end
      rises = ack_a & ~prev;
      if (rises != '0) begin
        chk("accepts_per_cycle", $countones(rises), 1);
        for (int i = 0; i < NA; i++) begin
          if (rises[i]) begin
            chk($sformatf("ack_ch%0d_expected", i), int'(qa[i].size() != 0), 1);
            if (qa[i].size() != 0) begin
              d = qa[i].pop_front();
              if (m_cnt < 65535) m_cnt++;
              if (d != m_exp[i] && !m_err) begin m_err = 1; m_ech = i; end
              m_exp[i] = m_exp[i] + 8'd1;
              log_a.push_back('{cyc, i});
            end
          end
        end
        chk("msg_cnt_a", int'(cnt_a), m_cnt);
        chk("err_a", int'(err_a), int'(m_err));
        chk("err_chnl_a", int'(ech_a), m_ech);
      end
      prev = ack_a;
    end
  end

  initial begin : mon_b
    logic prev;
    logic [DW-1:0] d;
    prev = 0; m_cntb = 0; m_errb = 0; m_expb = '0; n_rise_b = 0;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        m_cntb = 0; m_errb = 0; m_expb = '0; prev = 0; qb.delete();
        continue;
      end
      if (ack_b[0] && !prev) begin
        n_rise_b++;
        chk("ack_b_expected", int'(qb.size() != 0), 1);
        if (qb.size() != 0) begin
          d = qb.pop_front();
          if (m_cntb < 7) m_cntb++;
          if (d != m_expb) m_errb = 1;
          m_expb = m_expb + 8'd1;
        end
        chk("msg_cnt_b", int'(cnt_b), m_cntb);
        chk("err_b", int'(err_b), int'(m_errb));
      end
      prev = ack_b[0];
    end
  end

  task automatic wait_ack_a(int ch, logic v, string nm);
    int n = 0;
    while (ack_a[ch] !== v && n < 60) begin @(negedge clk); n++; end
    if (ack_a[ch] !== v) chk(nm, int'(ack_a[ch]), int'(v));
  endtask

  task automatic send_a(int ch, logic [DW-1:0] d);
    qa[ch].push_back(d);
    dat_a[ch*DW +: DW] = d;
    req_a[ch] = 1'b1;
    wait_ack_a(ch, 1'b1, $sformatf("ack_rise_ch%0d_timeout", ch));
    req_a[ch] = 1'b0;
    dat_a[ch*DW +: DW] = DW'($urandom);
    wait_ack_a(ch, 1'b0, $sformatf("ack_fall_ch%0d_timeout", ch));
  endtask

  task automatic send_b(logic [DW-1:0] d);
    int n = 0;
    qb.push_back(d);
    dat_b = d;
    req_b = 1'b1;
    while (ack_b[0] !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    if (ack_b[0] !== 1'b1) chk("ack_b_rise_timeout", int'(ack_b[0]), 1);
    req_b = 1'b0;
    dat_b = DW'($urandom);
    n = 0;
    while (ack_b[0] !== 1'b0 && n < 60) begin @(negedge clk); n++; end
    if (ack_b[0] !== 1'b0) chk("ack_b_fall_timeout", int'(ack_b[0]), 0);
  endtask

  logic [DW-1:0] nxt [NA];

  task automatic run_rand(int ch);
    repeat (6) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      send_a(ch, nxt[ch]);
      nxt[ch] = nxt[ch] + 8'd1;
    end
  endtask

  task automatic release_a();
    int n = 0;
    rst_a = 1'b0;
    while (!rdy_a && n < 20) begin @(negedge clk); n++; end
    chk("ready_latency_a", n, KS);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    rst_a = 1; rst_b = 1; req_a = '0; req_b = '0; dat_a = '0; dat_b = '0;
    foreach (nxt[i]) nxt[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset_ack_a", int'(ack_a), 0);
    chk("reset_ready_a", int'(rdy_a), 0);
    chk("reset_cnt_a", int'(cnt_a), 0);
    chk("reset_err_a", int'(err_a), 0);
    chk("reset_ech_a", int'(ech_a), 0);
    chk("reset_ack_b", int'(ack_b), 0);
    chk("reset_cnt_b", int'(cnt_b), 0);
    release_a();

    // all channels request together: grants must come out 0,1,2,3 on consecutive cycles
    fork
      send_a(0, 8'd0);
      send_a(1, 8'd0);
      send_a(2, 8'd0);
      send_a(3, 8'd0);
    join
    chk("rr_log_len", log_a.size(), 4);
    if (log_a.size() >= 4)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rr_order_%0d", k), log_a[k].ch, k);
        chk($sformatf("rr_cycle_%0d", k), log_a[k].cyc - log_a[0].cyc, k);
      end
    chk("cnt_after_rr", int'(cnt_a), 4);
    foreach (nxt[i]) nxt[i] = 8'd1;

    fork
      run_rand(0);
      run_rand(1);
      run_rand(2);
      run_rand(3);
    join
    chk("cnt_after_rand", int'(cnt_a), 28);
    chk("err_after_rand", int'(err_a), 0);

    // one-sample glitch on channel 1 must be filtered out
    req_a[1] = 1'b1;
    @(negedge clk);
    req_a[1] = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_ack", int'(ack_a), 0);
    chk("glitch_cnt", int'(cnt_a), 28);

    // reset while ack is high, with req held through and after reset
    qa[0].push_back(nxt[0]);
    dat_a[0 +: DW] = nxt[0];
    req_a[0] = 1'b1;
    wait_ack_a(0, 1'b1, "ack_rise_before_reset_timeout");
    rst_a = 1'b1;
    @(negedge clk);
    chk("midrst_ack", int'(ack_a), 0);
    chk("midrst_cnt", int'(cnt_a), 0);
    chk("midrst_ready", int'(rdy_a), 0);
    foreach (nxt[i]) nxt[i] = '0;
    release_a();
    repeat (8) @(negedge clk);
    chk("stale_req_no_ack", int'(ack_a), 0);
    chk("stale_req_no_cnt", int'(cnt_a), 0);
    req_a[0] = 1'b0;
    repeat (4) @(negedge clk);
    send_a(0, 8'd0);
    chk("restart_cnt", int'(cnt_a), 1);

    // sequence errors: first on channel 2, later on channel 1
    send_a(2, 8'd0);
    send_a(2, 8'd5);
    chk("seq_err_set", int'(err_a), 1);
    chk("seq_err_chnl", int'(ech_a), 2);
    send_a(1, 8'd9);
    chk("seq_err_sticky", int'(err_a), 1);
    chk("seq_err_chnl_sticky", int'(ech_a), 2);
    chk("seq_err_cnt", int'(cnt_a), 4);

    // single-channel instance: three clean messages, then saturation of the 3-bit counter
    rst_b = 1'b0;
    begin
      int n = 0;
      while (!rdy_b && n < 20) begin @(negedge clk); n++; end
      chk("ready_latency_b", n, KS);
    end
    for (int k = 0; k < 3; k++) send_b(DW'(k));
    chk("single_rises", n_rise_b, 3);
    chk("single_cnt", int'(cnt_b), 3);
    chk("single_err", int'(err_b), 0);
    for (int k = 3; k < 9; k++) send_b(DW'(k));
    chk("sat_cnt", int'(cnt_b), 7);
    chk("sat_err", int'(err_b), 0);
    chk("sat_rises", n_rise_b, 9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
